// File: rtl/obf_seq_pkg.sv
// ============================================================================
// Module : obf_seq_pkg
// Brief  : Shared widths, state encodings and LFSR taps for the obfuscation
//          expansion sequencer. Optional feature macro: OBF_KEY_ROLL_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef OBF_IGU_WIDTH
  `define OBF_IGU_WIDTH 8
`endif
`ifndef OBF_PPC_WIDTH
  `define OBF_PPC_WIDTH 8
`endif
`ifndef OBF_KEY_WIDTH
  `define OBF_KEY_WIDTH 8
`endif
`ifndef OBF_SEQ_LEN_WIDTH
  `define OBF_SEQ_LEN_WIDTH 4
`endif
`ifndef OBF_SEQ_IDLE
  `define OBF_SEQ_IDLE 1'b0
`endif
`ifndef OBF_SEQ_EXPAND
  `define OBF_SEQ_EXPAND 1'b1
`endif
`ifndef OBF_KEY_LFSR_TAPS
  `define OBF_KEY_LFSR_TAPS 32'h0000_00B8
`endif

package obf_seq_pkg;

  localparam int unsigned OBF_IGU_W  = `OBF_IGU_WIDTH;
  localparam int unsigned OBF_PPC_W  = `OBF_PPC_WIDTH;
  localparam int unsigned OBF_KEY_W  = `OBF_KEY_WIDTH;
  localparam int unsigned OBF_LEN_W  = `OBF_SEQ_LEN_WIDTH;
  localparam int unsigned OBF_PPC_STEP = 2;
  localparam logic [31:0] OBF_KEY_TAPS = `OBF_KEY_LFSR_TAPS;

  typedef enum logic [0:0] {
    SEQ_IDLE   = `OBF_SEQ_IDLE,
    SEQ_EXPAND = `OBF_SEQ_EXPAND
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/obf_seq_key_reg.sv
// ============================================================================
// Module : obf_key_reg
// Brief  : Obfuscation key register; with OBF_KEY_ROLL_EN defined the key
//          advances through a Galois LFSR on every completed sequence.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module obf_key_reg
  import obf_seq_pkg::*;
#(
  parameter int unsigned KEY_W = OBF_KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_we_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic             roll_i,
  output logic [KEY_W-1:0] key_o
);

  localparam logic [KEY_W-1:0] TAPS = KEY_W'(OBF_KEY_TAPS);

  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] key_d;

`ifdef OBF_KEY_ROLL_EN
  logic [KEY_W-1:0] roll_w;

  // Right-shifting Galois step; zero would lock the LFSR so it restarts at 1.
  always_comb begin
    roll_w = key_q >> 1;
    if (key_q == '0) begin
      roll_w = KEY_W'(1);
    end else if (key_q[0]) begin
      roll_w = (key_q >> 1) ^ TAPS;
    end
  end

  always_comb begin
    key_d = key_q;
    if (key_we_i) begin
      key_d = key_i;
    end else if (roll_i) begin
      key_d = roll_w;
    end
  end
`else
  logic unused_roll;
  logic [KEY_W-1:0] unused_taps;
  assign unused_roll = roll_i;
  assign unused_taps = TAPS;

  always_comb begin
    key_d = key_q;
    if (key_we_i) begin
      key_d = key_i;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
    end else begin
      key_q <= key_d;
    end
  end

  assign key_o = key_q;

endmodule

`default_nettype wire

// File: rtl/obf_seq.sv
// ============================================================================
// Module : obf_seq
// Brief  : Expansion sequencer feeding the obfuscation LUT: holds the IGU index
//          and steps the pseudo-PC per emitted substitute. Macro: OBF_KEY_ROLL_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module obf_seq
  import obf_seq_pkg::*;
#(
  parameter int unsigned IGU_W    = OBF_IGU_W,
  parameter int unsigned PPC_W    = OBF_PPC_W,
  parameter int unsigned KEY_W    = OBF_KEY_W,
  parameter int unsigned LEN_W    = OBF_LEN_W,
  parameter int unsigned PPC_STEP = OBF_PPC_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [IGU_W-1:0] if_index,
  input  logic [LEN_W-1:0] if_len,
  output logic             if_stall,
  input  logic             id_ready,
  input  logic             flush,
  input  logic             key_we,
  input  logic [KEY_W-1:0] key_in,
  output logic [IGU_W-1:0] lut_index,
  output logic [PPC_W-1:0] lut_ppc,
  output logic [KEY_W-1:0] lut_key,
  output logic             sub_valid,
  output logic             sub_last
);

  seq_state_e       state_q, state_d;
  logic [IGU_W-1:0] index_q, index_d;
  logic [PPC_W-1:0] ppc_q,   ppc_d;
  logic [LEN_W-1:0] rem_q,   rem_d;

  logic expand_w;
  logic last_w;
  logic done_w;

  assign expand_w = (state_q == SEQ_EXPAND);
  assign last_w   = expand_w && (rem_q == LEN_W'(1));
  assign done_w   = last_w && id_ready;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    ppc_d   = ppc_q;
    rem_d   = rem_q;

    if (flush) begin
      state_d = SEQ_IDLE;
      index_d = '0;
      ppc_d   = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        SEQ_IDLE: begin
          if (if_valid) begin
            state_d = SEQ_EXPAND;
            index_d = if_index;
            ppc_d   = '0;
            rem_d   = (if_len == '0) ? LEN_W'(1) : if_len;
          end
        end
        SEQ_EXPAND: begin
          if (id_ready) begin
            if (last_w) begin
              // Fetch was released this cycle, so a waiting entry is taken without a bubble.
              if (if_valid) begin
                state_d = SEQ_EXPAND;
                index_d = if_index;
                ppc_d   = '0;
                rem_d   = (if_len == '0) ? LEN_W'(1) : if_len;
              end else begin
                state_d = SEQ_IDLE;
                index_d = '0;
                ppc_d   = '0;
                rem_d   = '0;
              end
            end else begin
              rem_d = rem_q - LEN_W'(1);
              ppc_d = ppc_q + PPC_W'(PPC_STEP);
            end
          end
        end
        default: begin
          state_d = SEQ_IDLE;
          index_d = '0;
          ppc_d   = '0;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      index_q <= '0;
      ppc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      ppc_q   <= ppc_d;
      rem_q   <= rem_d;
    end
  end

  obf_key_reg #(
    .KEY_W (KEY_W)
  ) u_key_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_we_i (key_we),
    .key_i    (key_in),
    .roll_i   (done_w && !flush),
    .key_o    (lut_key)
  );

  assign lut_index = index_q;
  assign lut_ppc   = ppc_q;
  assign sub_valid = expand_w;
  assign sub_last  = last_w;
  assign if_stall  = expand_w && !done_w;

endmodule

`default_nettype wire

// File: tb/tb_obf_seq.sv
// ============================================================================
// Module : tb_obf_seq
// Brief  : Scoreboard bench for obf_seq: directed sequences, stalls, flush,
//          key load/roll and asynchronous reset. Macro: OBF_KEY_ROLL_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_obf_seq;
  import obf_seq_pkg::*;

  localparam int IW = OBF_IGU_W;
  localparam int PW = OBF_PPC_W;
  localparam int KW = OBF_KEY_W;
  localparam int LW = OBF_LEN_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_valid;
  logic [IW-1:0] if_index;
  logic [LW-1:0] if_len;
  logic          if_stall;
  logic          id_ready;
  logic          flush;
  logic          key_we;
  logic [KW-1:0] key_in;
  logic [IW-1:0] lut_index;
  logic [PW-1:0] lut_ppc;
  logic [KW-1:0] lut_key;
  logic          sub_valid;
  logic          sub_last;

  always #5 clk = ~clk;

  obf_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_valid  (if_valid),
    .if_index  (if_index),
    .if_len    (if_len),
    .if_stall  (if_stall),
    .id_ready  (id_ready),
    .flush     (flush),
    .key_we    (key_we),
    .key_in    (key_in),
    .lut_index (lut_index),
    .lut_ppc   (lut_ppc),
    .lut_key   (lut_key),
    .sub_valid (sub_valid),
    .sub_last  (sub_last)
  );

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [PW-1:0] ppc;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input int ppc, input bit last);
    exp_t e;
    e.idx  = IW'(idx);
    e.ppc  = PW'(ppc);
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every accepted substitute is matched against the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sub_valid && id_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_sub: got index %0h ppc %0h expected nothing", lut_index, lut_ppc);
      end else begin
        e = sb.pop_front();
        chk("mon_index", 64'(lut_index), 64'(e.idx));
        chk("mon_ppc",   64'(lut_ppc),   64'(e.ppc));
        chk("mon_last",  64'(sub_last),  64'(e.last));
        chk("mon_stall", 64'(if_stall),  64'(!e.last));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    if_valid = 1'b0;
    if_index = '0;
    if_len   = '0;
    id_ready = 1'b1;
    flush    = 1'b0;
    key_we   = 1'b0;
    key_in   = '0;
    tick();
    tick();
    chk("rst_sub_valid", 64'(sub_valid), 64'd0);
    chk("rst_sub_last",  64'(sub_last),  64'd0);
    chk("rst_stall",     64'(if_stall),  64'd0);
    chk("rst_index",     64'(lut_index), 64'd0);
    chk("rst_ppc",       64'(lut_ppc),   64'd0);
    chk("rst_key",       64'(lut_key),   64'd0);
    rst_n = 1'b1;
    tick();

    // index 27 len 3, decode always ready
    push(27, 0, 0); push(27, 2, 0); push(27, 4, 1);
    if_index = IW'(27); if_len = LW'(3); if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    chk("t1_latency", 64'(sub_valid), 64'd1);
    tick();
    tick();
    tick();
    chk("t1_idle", 64'(sub_valid), 64'd0);

    // same with decode stalled on the second substitute
    push(27, 0, 0); push(27, 2, 0); push(27, 4, 1);
    if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    tick();
    id_ready = 1'b0;
    tick();
    chk("t2_hold_ppc",   64'(lut_ppc),   64'd2);
    chk("t2_hold_index", 64'(lut_index), 64'd27);
    chk("t2_hold_valid", 64'(sub_valid), 64'd1);
    chk("t2_hold_stall", 64'(if_stall),  64'd1);
    id_ready = 1'b1;
    tick();
    tick();
    chk("t2_idle", 64'(sub_valid), 64'd0);

    // back-to-back: 29/len1 then 25/len2
    push(29, 0, 1);
    if_index = IW'(29); if_len = LW'(1); if_valid = 1'b1;
    tick();
    push(25, 0, 0); push(25, 2, 1);
    if_index = IW'(25); if_len = LW'(2);
    chk("t3_last",  64'(sub_last), 64'd1);
    chk("t3_stall", 64'(if_stall), 64'd0);
    tick();
    if_valid = 1'b0;
    chk("t3_no_bubble", 64'(sub_valid), 64'd1);
    chk("t3_index",     64'(lut_index), 64'd25);
    tick();
    tick();
    chk("t3_idle", 64'(sub_valid), 64'd0);

    // pass-through with len 0 treated as 1
    push(0, 0, 1);
    if_index = '0; if_len = '0; if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    chk("t4_pt_stall", 64'(if_stall), 64'd0);
    tick();
    chk("t4_pt_idle", 64'(sub_valid), 64'd0);

    // flush at ppc 2 of a len-4 sequence; the flush-cycle fetch is dropped
    push(9, 0, 0);
    if_index = IW'(9); if_len = LW'(4); if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    tick();
    chk("t5_pre_ppc", 64'(lut_ppc), 64'd2);
    id_ready = 1'b0; flush = 1'b1;
    if_valid = 1'b1; if_index = IW'(5); if_len = LW'(2);
    tick();
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    chk("t5_valid", 64'(sub_valid), 64'd0);
    chk("t5_ppc",   64'(lut_ppc),   64'd0);
    chk("t5_index", 64'(lut_index), 64'd0);
    chk("t5_stall", 64'(if_stall),  64'd0);
    tick();
    chk("t5_dropped", 64'(sub_valid), 64'd0);

    // key load in IDLE, then one completed sequence
    key_in = KW'(8'h5A); key_we = 1'b1;
    tick();
    key_we = 1'b0;
    chk("t6_key_load", 64'(lut_key), 64'h5A);
    push(4, 0, 1);
    if_index = IW'(4); if_len = LW'(1); if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    tick();
`ifdef OBF_KEY_ROLL_EN
    chk("t6_key_roll", 64'(lut_key), 64'h2D);
`else
    chk("t6_key_hold", 64'(lut_key), 64'h5A);
`endif
    // key write coincident with a sequence completion
    push(4, 0, 1);
    if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    key_in = KW'(8'h33); key_we = 1'b1;
    tick();
    key_we = 1'b0;
    chk("t6_key_we_wins", 64'(lut_key), 64'h33);

    // asynchronous reset in the middle of an expansion
    push(27, 0, 0);
    if_index = IW'(27); if_len = LW'(3); if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7_valid", 64'(sub_valid), 64'd0);
    chk("t7_last",  64'(sub_last),  64'd0);
    chk("t7_stall", 64'(if_stall),  64'd0);
    chk("t7_index", 64'(lut_index), 64'd0);
    chk("t7_ppc",   64'(lut_ppc),   64'd0);
    chk("t7_key",   64'(lut_key),   64'd0);
    tick();
    rst_n = 1'b1;
    push(3, 0, 0); push(3, 2, 1);
    if_index = IW'(3); if_len = LW'(2); if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    chk("t7_restart_ppc", 64'(lut_ppc), 64'd0);
    tick();
    tick();
    chk("t7_idle", 64'(sub_valid), 64'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/obf_seq.md
Name: obf_seq

Overview:
- Expansion sequencer directly upstream of the obfuscation LUT.
- Accepts one fetched instruction's substitution class (IGU index) plus sequence length from the instruction-group unit.
- Holds index stable and steps the pseudo-PC (ppc) so the LUT emits each substitute/immediate pair in order.
- Stalls fetch while a multi-instruction sequence drains into decode; also owns the obfuscation key register driven to the LUT.

Parameters:
- IGU_W, `OBF_IGU_WIDTH, width of LUT index
- PPC_W, `OBF_PPC_WIDTH, width of pseudo-PC
- KEY_W, `OBF_KEY_WIDTH, width of key
- LEN_W, 4, width of sequence-length field
- PPC_STEP, 2, ppc increment per emitted instruction (one sub word + one imm word)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetched instruction valid
- if_index  in  IGU_W  substitution class; 0 = pass-through
- if_len  in  LEN_W  number of substitutes; 0 treated as 1
- if_stall  out  1  hold fetch
- id_ready  in  1  decode accepts this cycle
- flush  in  1  branch/exception flush
- key_we  in  1  load key
- key_in  in  KEY_W  new key
- lut_index  out  IGU_W  to LUT index
- lut_ppc  out  PPC_W  to LUT ppc
- lut_key  out  KEY_W  to LUT key
- sub_valid  out  1  LUT output valid for decode
- sub_last  out  1  final instruction of sequence

Behaviour:
- Reset values: state IDLE, lut_index 0, lut_ppc 0, lut_key 0, sub_valid 0, sub_last 0, if_stall 0, remaining count 0.
- States: IDLE, EXPAND.
- IDLE:
  - On if_valid && !flush: latch index and len (len 0 becomes 1), set ppc 0, enter EXPAND next cycle.
  - Latency is one cycle from capture to the first sub_valid.
- EXPAND:
  - sub_valid = 1; sub_last = (remaining == 1).
  - If id_ready: remaining decrements; ppc += PPC_STEP, wrapping modulo 2^PPC_W.
  - On id_ready && sub_last: next cycle, if if_valid, capture the new entry (back-to-back, no bubble); otherwise return to IDLE.
  - If !id_ready: all outputs hold.
- if_stall:
  - = (state == EXPAND) && !(sub_last && id_ready). Registered-state based; no combinational path from if_valid.
- Flush:
  - Has priority over everything except reset.
  - Next cycle: state IDLE, sub_valid 0, ppc 0, index 0; the if_valid of the flush cycle is dropped.
- key_we:
  - lut_key <= key_in on the next edge, in any state.
  - A key written mid-sequence applies immediately: the LUT is combinational, and software writes keys only at sequence boundaries.
- lut_index/lut_ppc are registered outputs, glitch-free to the LUT.
- Reset asserted mid-sequence: outputs return to reset values immediately (asynchronous); no partial sequence resumes.
- Pass-through index 0, len 1: emits one instruction, no fetch stall.

Optional Feature:
- OBF_KEY_ROLL_EN defined:
  - lut_key advances via Galois LFSR (taps from obf_defines) on each completed sequence (sub_last && id_ready).
  - key_we has priority over the roll in the same cycle.
  - An all-zero key is replaced by 1 on roll.
- Undefined: lut_key changes only via key_we.

Decomposition:
- Shared defines (obf_defines.v): OBF_IGU_WIDTH, OBF_PPC_WIDTH, OBF_KEY_WIDTH, new OBF_SEQ_LEN_WIDTH, state encodings OBF_SEQ_IDLE/OBF_SEQ_EXPAND, LFSR tap constant.
- One sub-module, obf_key_reg: key register + optional LFSR roll, keeping the FSM file clean.

Test Plan:
- Reset, then if_valid, index 27, len 3, id_ready = 1 → sub_valid 3 cycles, ppc 0, 2, 4; sub_last on the 3rd; if_stall high for the first 2 EXPAND cycles.
- Same sequence with id_ready low on cycle 2 → ppc holds at 2 for that cycle; total 4 cycles; index stays 27.
- Back-to-back: index 29 len 1, then index 25 len 2, if_valid continuous → no idle cycle between sequences; ppc 0, then 0, 2.
- flush asserted while ppc = 2 of a len-4 sequence → next cycle sub_valid 0, ppc 0, index 0, if_stall 0.
- key_we with key_in 0x5A in IDLE → lut_key = 0x5A next cycle. With OBF_KEY_ROLL_EN, after one completed sequence lut_key = LFSR(0x5A). key_we coincident with roll → key_in wins.
- rst_n dropped mid-EXPAND (asynchronous, between edges) → all outputs 0 immediately; after release, a new if_valid starts at ppc 0.
